// File: rtl/ob_mk_match.sv
// ob_mk_match: matches a market command against the head of an upstream limit table.
// Defining OB_MK_MATCH_STATS_EN adds the 32-bit trade counter output trd_cnt_r.
package ob_pkg;
  typedef logic [15:0] uid_t;
  typedef logic [15:0] quantity_t;
  typedef logic [15:0] price_t;
  typedef struct packed {
    price_t    price;
    uid_t      uid;
    quantity_t quantity;
  } table_t;
endpackage

module ob_mk_match (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  ob_pkg::uid_t      cmd_uid,
  input  ob_pkg::quantity_t cmd_qty,
  input  logic              head_vld_r,
  input  ob_pkg::table_t    head_r,
  input  logic              head_did_update_r,
  output logic              head_pop,
  output logic              head_upt,
  output ob_pkg::table_t    head_upt_tbl,
  output logic              trd_vld_r,
  input  logic              trd_rdy,
  output ob_pkg::uid_t      trd_uid_a,
  output ob_pkg::uid_t      trd_uid_p,
  output ob_pkg::quantity_t trd_qty,
  output logic              rsp_vld_r,
  output ob_pkg::uid_t      rsp_uid,
  output ob_pkg::quantity_t rsp_rem_qty,
  output logic              busy_r
`ifdef OB_MK_MATCH_STATS_EN
  ,
  output logic [31:0]       trd_cnt_r
`endif
);
  import ob_pkg::*;

  typedef enum logic [1:0] {IDLE, MATCH, SETTLE, RSP} state_t;

  state_t    state_q, state_d;
  uid_t      uid_q, uid_d;
  quantity_t rem_q, rem_d;
  logic      trd_vld_q, trd_vld_d;
  uid_t      trd_uid_a_q, trd_uid_a_d;
  uid_t      trd_uid_p_q, trd_uid_p_d;
  quantity_t trd_qty_q, trd_qty_d;
  logic      pop_d, upt_d, trd_load;
  table_t    upt_tbl_d;
  logic      slot_free, head_fits;

  // The fixed one-cycle SETTLE already covers the table's update latency.
  logic      unused_head_upd;
  assign unused_head_upd = head_did_update_r;

  assign slot_free = ~trd_vld_q | trd_rdy;
  assign head_fits = (head_r.quantity <= rem_q);

  always_comb begin
    state_d     = state_q;
    uid_d       = uid_q;
    rem_d       = rem_q;
    trd_uid_a_d = trd_uid_a_q;
    trd_uid_p_d = trd_uid_p_q;
    trd_qty_d   = trd_qty_q;
    pop_d       = 1'b0;
    upt_d       = 1'b0;
    trd_load    = 1'b0;
    upt_tbl_d   = head_r;
    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          uid_d   = cmd_uid;
          rem_d   = cmd_qty;
          state_d = MATCH;
        end
      end
      MATCH: begin
        if ((rem_q == '0) || !head_vld_r) begin
          state_d = RSP;
        end else if (slot_free) begin
          state_d = SETTLE;
          if (head_fits) begin
            pop_d = 1'b1;
            rem_d = rem_q - head_r.quantity;
          end else begin
            upt_d              = 1'b1;
            upt_tbl_d.quantity = head_r.quantity - rem_q;
            rem_d              = '0;
          end
          // An empty head entry is consumed without producing a trade.
          if (head_r.quantity != '0) begin
            trd_load    = 1'b1;
            trd_uid_a_d = uid_q;
            trd_uid_p_d = head_r.uid;
            trd_qty_d   = head_fits ? head_r.quantity : rem_q;
          end
        end
      end
      SETTLE:  state_d = MATCH;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    trd_vld_d = trd_load | (trd_vld_q & ~trd_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      uid_q       <= '0;
      rem_q       <= '0;
      trd_vld_q   <= 1'b0;
      trd_uid_a_q <= '0;
      trd_uid_p_q <= '0;
      trd_qty_q   <= '0;
    end else begin
      state_q     <= state_d;
      uid_q       <= uid_d;
      rem_q       <= rem_d;
      trd_vld_q   <= trd_vld_d;
      trd_uid_a_q <= trd_uid_a_d;
      trd_uid_p_q <= trd_uid_p_d;
      trd_qty_q   <= trd_qty_d;
    end
  end

  assign cmd_rdy      = (state_q == IDLE);
  assign busy_r       = (state_q != IDLE);
  assign head_pop     = pop_d & ~rst;
  assign head_upt     = upt_d & ~rst;
  assign head_upt_tbl = upt_tbl_d;
  assign trd_vld_r    = trd_vld_q;
  assign trd_uid_a    = trd_uid_a_q;
  assign trd_uid_p    = trd_uid_p_q;
  assign trd_qty      = trd_qty_q;
  assign rsp_vld_r    = (state_q == RSP);
  assign rsp_uid      = uid_q;
  assign rsp_rem_qty  = rem_q;

`ifdef OB_MK_MATCH_STATS_EN
  logic [31:0] trd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trd_cnt_q <= '0;
    end else if (trd_load) begin
      trd_cnt_q <= trd_cnt_q + 32'd1;
    end
  end

  assign trd_cnt_r = trd_cnt_q;
`endif

endmodule

// File: tb/tb_ob_mk_match.sv
// Self-checking bench for ob_mk_match: a queue-based limit table plus a walk-the-book reference model.
module tb_ob_mk_match;
  import ob_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      cmd_vld = 1'b0;
  uid_t      cmd_uid = '0;
  quantity_t cmd_qty = '0;
  logic      cmd_rdy;
  logic      head_vld_r = 1'b0;
  table_t    head_r = '0;
  logic      head_did_update_r = 1'b0;
  logic      head_pop, head_upt;
  table_t    head_upt_tbl;
  logic      trd_vld_r;
  logic      trd_rdy = 1'b1;
  uid_t      trd_uid_a, trd_uid_p;
  quantity_t trd_qty;
  logic      rsp_vld_r;
  uid_t      rsp_uid;
  quantity_t rsp_rem_qty;
  logic      busy_r;
`ifdef OB_MK_MATCH_STATS_EN
  logic [31:0] trd_cnt_r;
`endif

  always #5 clk = ~clk;

  ob_mk_match dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_uid(cmd_uid), .cmd_qty(cmd_qty),
    .head_vld_r(head_vld_r), .head_r(head_r), .head_did_update_r(head_did_update_r),
    .head_pop(head_pop), .head_upt(head_upt), .head_upt_tbl(head_upt_tbl),
    .trd_vld_r(trd_vld_r), .trd_rdy(trd_rdy), .trd_uid_a(trd_uid_a), .trd_uid_p(trd_uid_p),
    .trd_qty(trd_qty),
    .rsp_vld_r(rsp_vld_r), .rsp_uid(rsp_uid), .rsp_rem_qty(rsp_rem_qty),
    .busy_r(busy_r)
`ifdef OB_MK_MATCH_STATS_EN
    , .trd_cnt_r(trd_cnt_r)
`endif
  );

  typedef struct { int a; int p; int q; } trd_t;
  typedef struct {
    bit   is_upt;
    int   uid;
    int   price;
    int   new_qty;
    bit   has_trd;
    trd_t trd;
  } act_t;

  // Upstream table: front of the queue is the head.
  table_t book[$];
  table_t nb[$];
  int     load_seq = 0;
  int     load_seen = 0;
  bit     pend_pop = 1'b0;
  bit     pend_upt = 1'b0;
  quantity_t pend_qty = '0;

  always @(posedge clk) begin
    #1;
    if (load_seq != load_seen) begin
      book = nb;
      load_seen = load_seq;
    end else if (pend_pop && book.size() > 0) begin
      book.delete(0);
    end else if (pend_upt && book.size() > 0) begin
      book[0].quantity = pend_qty;
    end
    head_did_update_r = pend_pop || pend_upt;
    head_vld_r = (book.size() != 0);
    head_r = (book.size() != 0) ? book[0] : '0;
  end

  // Literal expectations for directed commands, indexed by command order.
  bit pin_en   [0:15];
  int pin_ntrd [0:15];
  int pin_tq   [0:15][0:1];
  int pin_tp   [0:15][0:1];
  int pin_rem  [0:15];
  int pin_nupt [0:15];
  int pin_uptq [0:15];

  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  bit   in_cmd = 1'b0;
  int   acc_t = 0;
  int   last_act = -10;
  bit   had_act = 1'b0;
  int   cur_uid = 0;
  int   exp_rem = 0;
  act_t exp_act[$];
  trd_t inflight[$];
  bit   trd_due = 1'b0;
  trd_t due_trd;
  bit   prev_stall = 1'b0;
  trd_t prev_trd;
  int   exp_cnt = 0;
  int   ncmd_acc = 0;
  bit   done = 1'b0;
  bit   final_done = 1'b0;
  bit   busy_exp, act_exp, rsp_exp, slot_free;
  act_t a;
  trd_t tt;
  int   rem, idx, bq, nt, nu;

  task automatic chk(input string nm, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, t);
    end
  endtask

  always @(negedge clk) begin
    t = t + 1;
    pend_pop = 1'b0;
    pend_upt = 1'b0;
    if (rst) begin
      chk("rst_head_pop", int'(head_pop), 0);
      chk("rst_head_upt", int'(head_upt), 0);
      in_cmd = 1'b0;
      exp_act.delete();
      inflight.delete();
      prev_stall = 1'b0;
      trd_due = 1'b0;
      exp_cnt = 0;
    end else begin
      busy_exp  = in_cmd && (t > acc_t);
      slot_free = !trd_vld_r || trd_rdy;
      act_exp   = busy_exp && (exp_act.size() > 0) && (t != last_act + 1) && slot_free;
      rsp_exp   = busy_exp && (exp_act.size() == 0) && (t == (had_act ? last_act + 3 : acc_t + 2));
      chk("busy", int'(busy_r), int'(busy_exp));
      chk("cmd_rdy", int'(cmd_rdy), int'(!busy_exp));
      chk("head_action", int'(head_pop || head_upt), int'(act_exp));
      chk("pop_upt_excl", int'(head_pop && head_upt), 0);
      chk("rsp_vld", int'(rsp_vld_r), int'(rsp_exp));
      if (rsp_exp && rsp_vld_r) begin
        chk("rsp_uid", int'(rsp_uid), cur_uid);
        chk("rsp_rem", int'(rsp_rem_qty), exp_rem);
      end
      if (trd_due) begin
        chk("trd_load_vld", int'(trd_vld_r), 1);
        chk("trd_load_qty", int'(trd_qty), due_trd.q);
        chk("trd_load_p", int'(trd_uid_p), due_trd.p);
        chk("trd_load_a", int'(trd_uid_a), due_trd.a);
      end
      if (prev_stall) begin
        chk("trd_hold_vld", int'(trd_vld_r), 1);
        chk("trd_hold_qty", int'(trd_qty), prev_trd.q);
        chk("trd_hold_p", int'(trd_uid_p), prev_trd.p);
        chk("trd_hold_a", int'(trd_uid_a), prev_trd.a);
      end
      if (trd_vld_r && trd_rdy) begin
        if (inflight.size() == 0) begin
          chk("trd_unexpected", 1, 0);
        end else begin
          tt = inflight.pop_front();
          chk("trd_qty", int'(trd_qty), tt.q);
          chk("trd_uid_p", int'(trd_uid_p), tt.p);
          chk("trd_uid_a", int'(trd_uid_a), tt.a);
        end
      end else if (trd_vld_r && inflight.size() == 0) begin
        chk("trd_spurious", 1, 0);
      end
`ifdef OB_MK_MATCH_STATS_EN
      chk("trd_cnt", int'(trd_cnt_r), exp_cnt);
`endif
      trd_due = 1'b0;
      if (act_exp && (head_pop || head_upt)) begin
        a = exp_act.pop_front();
        chk("act_kind_upt", int'(head_upt), int'(a.is_upt));
        if (head_upt) begin
          chk("upt_uid", int'(head_upt_tbl.uid), a.uid);
          chk("upt_price", int'(head_upt_tbl.price), a.price);
          chk("upt_qty", int'(head_upt_tbl.quantity), a.new_qty);
        end
        last_act = t;
        had_act = 1'b1;
        if (a.has_trd) begin
          inflight.push_back(a.trd);
          due_trd = a.trd;
          trd_due = 1'b1;
          exp_cnt = exp_cnt + 1;
        end
      end
      prev_stall = trd_vld_r && !trd_rdy;
      prev_trd.a = int'(trd_uid_a);
      prev_trd.p = int'(trd_uid_p);
      prev_trd.q = int'(trd_qty);
      if (rsp_exp) in_cmd = 1'b0;
      pend_pop = head_pop;
      pend_upt = head_upt;
      pend_qty = head_upt_tbl.quantity;

      if (cmd_vld && cmd_rdy) begin
        rem = int'(cmd_qty);
        idx = 0;
        exp_act.delete();
        while (rem != 0 && idx < int'(book.size())) begin
          bq = int'(book[idx].quantity);
          a.uid = int'(book[idx].uid);
          a.price = int'(book[idx].price);
          a.trd.a = int'(cmd_uid);
          a.trd.p = int'(book[idx].uid);
          if (bq <= rem) begin
            a.is_upt = 1'b0;
            a.new_qty = 0;
            a.has_trd = (bq != 0);
            a.trd.q = bq;
            rem = rem - bq;
            idx = idx + 1;
          end else begin
            a.is_upt = 1'b1;
            a.new_qty = bq - rem;
            a.has_trd = 1'b1;
            a.trd.q = rem;
            rem = 0;
          end
          exp_act.push_back(a);
        end
        exp_rem = rem;
        if (ncmd_acc < 16 && pin_en[ncmd_acc]) begin
          nt = 0;
          nu = 0;
          foreach (exp_act[k]) begin
            if (exp_act[k].has_trd) begin
              if (nt < 2) begin
                chk("pin_trd_qty", exp_act[k].trd.q, pin_tq[ncmd_acc][nt]);
                chk("pin_trd_p", exp_act[k].trd.p, pin_tp[ncmd_acc][nt]);
              end
              nt = nt + 1;
            end
            if (exp_act[k].is_upt) begin
              nu = nu + 1;
              chk("pin_upt_qty", exp_act[k].new_qty, pin_uptq[ncmd_acc]);
            end
          end
          chk("pin_ntrd", nt, pin_ntrd[ncmd_acc]);
          chk("pin_nupt", nu, pin_nupt[ncmd_acc]);
          chk("pin_rem", rem, pin_rem[ncmd_acc]);
        end
        ncmd_acc = ncmd_acc + 1;
        in_cmd = 1'b1;
        acc_t = t;
        had_act = 1'b0;
        last_act = -10;
        cur_uid = int'(cmd_uid);
      end

      if (done && !final_done) begin
        chk("end_inflight", inflight.size(), 0);
        chk("end_actions", exp_act.size(), 0);
        chk("end_idle", int'(in_cmd), 0);
        final_done = 1'b1;
      end
    end
  end

  // Stimulus
  int rdy_mode = 0;
  int issued = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (rdy_mode == 0) trd_rdy = 1'b1;
    else if (rdy_mode == 1) trd_rdy = ($urandom_range(0, 9) < 7);
  endtask

  function automatic table_t ent(input int uid, input int q, input int price);
    table_t e;
    e.price = 16'(price);
    e.uid = 16'(uid);
    e.quantity = 16'(q);
    return e;
  endfunction

  task automatic apply_book();
    load_seq = load_seq + 1;
    tick();
    tick();
  endtask

  task automatic pin(input int ntrd, input int q0, input int p0, input int q1, input int p1,
                     input int rem_v, input int nupt, input int uptq);
    pin_en[issued] = 1'b1;
    pin_ntrd[issued] = ntrd;
    pin_tq[issued][0] = q0;
    pin_tp[issued][0] = p0;
    pin_tq[issued][1] = q1;
    pin_tp[issued][1] = p1;
    pin_rem[issued] = rem_v;
    pin_nupt[issued] = nupt;
    pin_uptq[issued] = uptq;
  endtask

  task automatic issue_cmd(input int uid, input int qty);
    int n;
    n = 0;
    while (!cmd_rdy) begin
      tick();
      n = n + 1;
      if (n > 200) begin
        $display("FAIL cmd_rdy_timeout: cmd_rdy still 0 after 200 cycles, required 1");
        $fatal(1);
      end
    end
    cmd_vld = 1'b1;
    cmd_uid = 16'(uid);
    cmd_qty = 16'(qty);
    issued = issued + 1;
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_r || trd_vld_r) begin
      tick();
      n = n + 1;
      if (n > 400) begin
        $display("FAIL idle_timeout: busy_r=%0d trd_vld_r=%0d after 400 cycles, required 0", busy_r, trd_vld_r);
        $fatal(1);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Two heads: pop one, partially fill the next.
    nb.delete(); nb.push_back(ent(7, 4, 100)); nb.push_back(ent(9, 20, 101));
    apply_book(); pin(2, 4, 7, 6, 9, 0, 1, 14); issue_cmd(16'h11, 10); wait_idle();
    // Book runs dry with remainder.
    nb.delete(); nb.push_back(ent(5, 3, 100));
    apply_book(); pin(1, 3, 5, 0, 0, 7, 0, 0); issue_cmd(16'h12, 10); wait_idle();
    // Exact fill.
    nb.delete(); nb.push_back(ent(6, 5, 100));
    apply_book(); pin(1, 5, 6, 0, 0, 0, 0, 0); issue_cmd(16'h13, 5); wait_idle();
    // Backpressure on the first trade.
    nb.delete(); nb.push_back(ent(1, 2, 100)); nb.push_back(ent(2, 3, 100));
    apply_book(); pin(2, 2, 1, 3, 2, 5, 0, 0);
    rdy_mode = 2; trd_rdy = 1'b1;
    issue_cmd(16'h14, 10);
    for (int i = 0; i < 50 && !trd_vld_r; i++) tick();
    trd_rdy = 1'b0;
    repeat (4) tick();
    trd_rdy = 1'b1;
    wait_idle();
    rdy_mode = 0;
    // Zero-quantity command.
    nb.delete(); nb.push_back(ent(8, 6, 100));
    apply_book(); pin(0, 0, 0, 0, 0, 0, 0, 0); issue_cmd(16'h15, 0); wait_idle();
    // Empty head entry popped without a trade.
    nb.delete(); nb.push_back(ent(3, 0, 100)); nb.push_back(ent(4, 9, 102));
    apply_book(); pin(1, 3, 4, 0, 0, 0, 1, 6); issue_cmd(16'h16, 3); wait_idle();
    // Reset while in SETTLE.
    nb.delete(); nb.push_back(ent(1, 2, 100)); nb.push_back(ent(2, 2, 100));
    apply_book(); issue_cmd(16'h17, 10);
    for (int i = 0; i < 50 && !head_pop; i++) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    nb.delete(); nb.push_back(ent(5, 5, 100));
    apply_book(); pin(1, 2, 5, 0, 0, 0, 1, 3); issue_cmd(16'h18, 2); wait_idle();

    rdy_mode = 1;
    for (int n = 0; n < 120; n++) begin
      nb.delete();
      for (int e = 0; e < int'($urandom_range(0, 4)); e++)
        nb.push_back(ent(int'($urandom_range(1, 255)), int'($urandom_range(0, 12)), int'($urandom_range(0, 999))));
      apply_book();
      issue_cmd(int'($urandom_range(256, 4000)), int'($urandom_range(0, 30)));
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(0, 5)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
      end else begin
        wait_idle();
      end
    end
    rdy_mode = 0;
    wait_idle();

    done = 1'b1;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
